// File: rtl/pulse_meter_pkg.sv
// rtl/pulse_meter_pkg.sv - shared state encoding and default widths for pulse_meter
package pulse_meter_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_CNT_PC = 16;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    IDLE      = 2'd1,
    MEASURE   = 2'd2,
    OVERRANGE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer with async active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - measures width of an asynchronous sync pulse in clock cycles
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int CNT_PC = DEF_CNT_PC
) (
  input  logic              clk_Meter,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic [CNT_W-1:0]  min_width,
  input  logic [CNT_W-1:0]  max_width,
  output logic [CNT_W-1:0]  width_out,
  output logic              valid,
  output logic              err_short,
  output logic              err_long,
  output logic              busy,
  output logic [CNT_PC-1:0] pulse_count
);

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_PC-1:0] PC_ONE  = CNT_PC'(1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       primed_q;

  logic             ev_valid_q, ev_valid_d;
  logic             ev_short_q, ev_short_d;
  logic             ev_long_q, ev_long_d;
  logic [CNT_W-1:0] ev_width_q, ev_width_d;

  logic [CNT_W-1:0]  width_q;
  logic              valid_q, short_q, long_q, busy_q;
  logic [CNT_PC-1:0] pcount_q;

  sync_2ff u_sync (
    .clk   (clk_Meter),
    .rst_n (rst_n),
    .d_i   (pulse_in),
    .q_o   (s)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  // ARM ignores s until the synchronizer holds a real sample, so a pulse
  // already high at reset release is seen as high and skipped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ev_valid_d = 1'b0;
    ev_short_d = 1'b0;
    ev_long_d  = 1'b0;
    ev_width_d = ev_width_q;
    case (state_q)
      ARM: begin
        if (primed_q[1] && !s) state_d = IDLE;
      end
      IDLE: begin
        if (s) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end
      end
      MEASURE: begin
        if (s) begin
          cnt_d = cnt_inc;
          if ((max_width != '0) && (cnt_inc > max_width)) begin
            state_d   = OVERRANGE;
            ev_long_d = 1'b1;
          end
        end else begin
          state_d    = IDLE;
          ev_valid_d = 1'b1;
          ev_width_d = cnt_q;
          ev_short_d = (min_width != '0) && (cnt_q < min_width);
        end
      end
      OVERRANGE: begin
        if (!s) state_d = IDLE;
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk_Meter or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARM;
      cnt_q      <= '0;
      primed_q   <= 2'b00;
      ev_valid_q <= 1'b0;
      ev_short_q <= 1'b0;
      ev_long_q  <= 1'b0;
      ev_width_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      primed_q   <= {primed_q[0], 1'b1};
      ev_valid_q <= ev_valid_d;
      ev_short_q <= ev_short_d;
      ev_long_q  <= ev_long_d;
      ev_width_q <= ev_width_d;
    end
  end

  // Output stage: strobes trail the FSM decision by one register.
  always_ff @(posedge clk_Meter or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= '0;
      valid_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
      pcount_q <= '0;
    end else begin
      if (ev_valid_q) begin
        width_q  <= ev_width_q;
        pcount_q <= pcount_q + PC_ONE;
      end
      valid_q <= ev_valid_q;
      short_q <= ev_short_q;
      long_q  <= ev_long_q;
      busy_q  <= (state_d == MEASURE) || (state_d == OVERRANGE);
    end
  end

  assign width_out   = width_q;
  assign valid       = valid_q;
  assign err_short   = short_q;
  assign err_long    = long_q;
  assign busy        = busy_q;
  assign pulse_count = pcount_q;

endmodule

// File: tb/tb_pulse_meter.sv
// tb/tb_pulse_meter.sv - self-checking bench for pulse_meter
module tb_pulse_meter;

  localparam int CNT_W  = 8;
  localparam int CNT_PC = 4;
  localparam int EV_MAX = 512;
  localparam int K_VALID = 1;
  localparam int K_LONG  = 2;

  logic              clk_Meter = 1'b0;
  logic              rst_n;
  logic              pulse_in;
  logic [CNT_W-1:0]  min_width;
  logic [CNT_W-1:0]  max_width;
  logic [CNT_W-1:0]  width_out;
  logic              valid;
  logic              err_short;
  logic              err_long;
  logic              busy;
  logic [CNT_PC-1:0] pulse_count;

  pulse_meter #(.CNT_W(CNT_W), .CNT_PC(CNT_PC)) dut (
    .clk_Meter   (clk_Meter),
    .rst_n       (rst_n),
    .pulse_in    (pulse_in),
    .min_width   (min_width),
    .max_width   (max_width),
    .width_out   (width_out),
    .valid       (valid),
    .err_short   (err_short),
    .err_long    (err_long),
    .busy        (busy),
    .pulse_count (pulse_count)
  );

  always #5 clk_Meter = ~clk_Meter;

  typedef struct {
    int n;
    int mn;
    int mx;
    bit e_valid;
    int e_w;
    bit e_short;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int pc_model = 0;

  int   ev_n = 0;
  int   ev_kind [EV_MAX];
  int   ev_w    [EV_MAX];
  int   ev_s    [EV_MAX];
  int   mon_bad = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk_Meter) begin
    if ((valid || err_long) && ev_n < EV_MAX) begin
      ev_kind[ev_n] <= valid ? K_VALID : K_LONG;
      ev_w[ev_n]    <= int'(width_out);
      ev_s[ev_n]    <= int'(err_short);
      ev_n          <= ev_n + 1;
    end
    prev_valid <= valid;
    mon_bad <= mon_bad + int'(valid && prev_valid) + int'(err_short && !valid)
               + int'(err_long && valid);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is positioned #1 after a posedge; pulse is sampled high on n edges, low on gap edges.
  task automatic pulse(input int n, input int gap);
    pulse_in = 1'b1;
    repeat (n) @(posedge clk_Meter);
    #1 pulse_in = 1'b0;
    repeat (gap) @(posedge clk_Meter);
    #1;
  endtask

  function automatic void model(input int n, input int mn, input int mx,
                                output int kind, output int w, output int s);
    kind = (mx != 0 && n > mx) ? K_LONG : K_VALID;
    w    = (n > 255) ? 255 : n;
    s    = (kind == K_VALID && mn != 0 && n < mn) ? 1 : 0;
  endfunction

  vec_t tbl [10];
  int   exp_kind [$];
  int   exp_w    [$];
  int   exp_s    [$];

  initial begin
    int base, first, nv, nl, kind, w, s, n, gap, mn, mx;

    tbl[0] = '{10, 0, 0, 1'b1, 10, 1'b0};
    tbl[1] = '{ 4, 5, 0, 1'b1,  4, 1'b1};
    tbl[2] = '{ 5, 5, 0, 1'b1,  5, 1'b0};
    tbl[3] = '{20, 0, 8, 1'b0,  0, 1'b0};
    tbl[4] = '{ 8, 0, 8, 1'b1,  8, 1'b0};
    tbl[5] = '{ 9, 0, 8, 1'b0,  0, 1'b0};
    tbl[6] = '{ 1, 0, 0, 1'b1,  1, 1'b0};
    tbl[7] = '{ 1, 2, 0, 1'b1,  1, 1'b1};
    tbl[8] = '{ 3, 3, 3, 1'b1,  3, 1'b0};
    tbl[9] = '{ 6, 7, 5, 1'b0,  0, 1'b0};

    rst_n = 1'b0; pulse_in = 1'b0; min_width = '0; max_width = '0;
    repeat (2) @(posedge clk_Meter);
    #1;
    chk("reset_width", width_out, 0);
    chk("reset_flags", {valid, err_short, err_long, busy}, 0);
    chk("reset_count", pulse_count, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk_Meter);
    #1;

    for (int i = 0; i < 10; i++) begin
      min_width = CNT_W'(tbl[i].mn);
      max_width = CNT_W'(tbl[i].mx);
      base = ev_n;
      pulse(tbl[i].n, 8);
      chk($sformatf("tbl%0d_events", i), ev_n - base, 1);
      chk($sformatf("tbl%0d_kind", i), ev_kind[base], tbl[i].e_valid ? K_VALID : K_LONG);
      if (tbl[i].e_valid) begin
        pc_model++;
        chk($sformatf("tbl%0d_width", i), ev_w[base], tbl[i].e_w);
        chk($sformatf("tbl%0d_short", i), ev_s[base], int'(tbl[i].e_short));
      end
      chk($sformatf("tbl%0d_count", i), pulse_count, pc_model % 16);
    end

    min_width = '0; max_width = '0;
    pulse_in = 1'b1;
    repeat (3) @(posedge clk_Meter);
    #1 pulse_in = 1'b0;
    first = 0; nv = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_Meter); @(negedge clk_Meter);
      if (valid) begin
        nv++;
        if (first == 0) first = k;
        chk("latency_width", width_out, 3);
      end
    end
    pc_model++;
    chk("valid_latency_edge", first, 4);
    chk("valid_one_cycle", nv, 1);
    @(posedge clk_Meter); #1;

    max_width = 8'd8;
    base = ev_n; first = 0; nl = 0; nv = 0;
    pulse_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_Meter); @(negedge clk_Meter);
      if (err_long) begin nl++; if (first == 0) first = k; end
      if (valid) nv++;
      if (k == 15) chk("long_busy_held", busy, 1);
    end
    pulse_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_Meter); @(negedge clk_Meter);
      if (err_long) nl++;
      if (valid) nv++;
    end
    chk("long_busy_released", busy, 0);
    chk("long_edge", first, 12);
    chk("long_once", nl, 1);
    chk("long_no_valid", nv, 0);
    @(posedge clk_Meter); #1;
    max_width = '0;

    min_width = '0;
    base = ev_n;
    pulse_in = 1'b1;
    repeat (2) @(posedge clk_Meter);
    #1 min_width = 8'd6;
    repeat (2) @(posedge clk_Meter);
    #1 pulse_in = 1'b0;
    repeat (8) @(posedge clk_Meter);
    #1;
    pc_model++;
    chk("midchange_width", ev_w[base], 4);
    chk("midchange_short", ev_s[base], 1);
    min_width = '0;

    base = ev_n;
    pulse(300, 8);
    pc_model++;
    chk("saturate_events", ev_n - base, 1);
    chk("saturate_width", ev_w[base], 255);

    rst_n = 1'b0; pulse_in = 1'b1;
    repeat (2) @(posedge clk_Meter);
    #1;
    chk("rst2_width", width_out, 0);
    chk("rst2_count", pulse_count, 0);
    rst_n = 1'b1;
    pc_model = 0;
    base = ev_n;
    repeat (6) @(posedge clk_Meter);
    #1 pulse_in = 1'b0;
    repeat (4) @(posedge clk_Meter);
    #1;
    pulse(3, 8);
    pc_model++;
    chk("rearm_events", ev_n - base, 1);
    chk("rearm_width", ev_w[base], 3);
    chk("rearm_count", pulse_count, pc_model % 16);

    base = ev_n;
    pulse_in = 1'b1;
    repeat (4) @(posedge clk_Meter);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {width_out, valid, err_short, err_long, busy, pulse_count}, 0);
    @(posedge clk_Meter);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk_Meter);
    #1 pulse_in = 1'b0;
    repeat (10) @(posedge clk_Meter);
    #1;
    pc_model = 0;
    chk("midrst_no_event", ev_n - base, 0);
    chk("midrst_count", pulse_count, 0);

    base = ev_n;
    for (int i = 0; i < 16; i++) pulse(2, 1);
    pulse(2, 8);
    pc_model += 17;
    chk("b2b_events", ev_n - base, 17);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("b2b%0d_width", i), ev_w[base + i], 2);
    end
    chk("b2b_wrap_count", pulse_count, pc_model % 16);

    base = ev_n;
    for (int i = 0; i < 40; i++) begin
      n   = $urandom_range(1, 20);
      gap = $urandom_range(3, 6);
      mn  = $urandom_range(0, 12);
      mx  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 16);
      min_width = CNT_W'(mn);
      max_width = CNT_W'(mx);
      model(n, mn, mx, kind, w, s);
      exp_kind.push_back(kind);
      exp_w.push_back(w);
      exp_s.push_back(s);
      if (kind == K_VALID) pc_model++;
      pulse(n, gap);
    end
    repeat (8) @(posedge clk_Meter);
    #1;
    chk("rand_events", ev_n - base, exp_kind.size());
    for (int i = 0; i < exp_kind.size(); i++) begin
      chk($sformatf("rand%0d_kind", i), ev_kind[base + i], exp_kind[i]);
      if (exp_kind[i] == K_VALID) begin
        chk($sformatf("rand%0d_width", i), ev_w[base + i], exp_w[i]);
        chk($sformatf("rand%0d_short", i), ev_s[base + i], exp_s[i]);
      end
    end
    chk("rand_count", pulse_count, pc_model % 16);
    chk("strobe_anomalies", mon_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of the measurement counter and the width thresholds.
REQ-002 Parameter CNT_PC, default 16, width of the accepted-pulse counter.
REQ-003 clk_Meter  input  1  single clock; all logic rises on its posedge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pulse_in  input  1  asynchronous optical sync pulse, active-high.
REQ-006 min_width  input  CNT_W  shortest legal width in clocks; 0 disables the short check.
REQ-007 max_width  input  CNT_W  longest legal width in clocks; 0 disables the long check.
REQ-008 width_out  output  CNT_W  last measured width in clocks; holds until the next measurement.
REQ-009 valid  output  1  one-cycle strobe marking a new width_out.
REQ-010 err_short  output  1  one-cycle strobe, coincident with valid, when width_out < min_width.
REQ-011 err_long  output  1  one-cycle strobe when a pulse exceeds max_width.
REQ-012 busy  output  1  high while in MEASURE or OVERRANGE.
REQ-013 pulse_count  output  CNT_PC  number of valid strobes since reset.

Function
REQ-014 pulse_in SHALL pass through a 2-flop synchronizer; the logic SHALL use only its output s.
REQ-015 The FSM SHALL have exactly four states: ARM, IDLE, MEASURE, OVERRANGE.
REQ-016 ARM: stay while s=1; go to IDLE on the first cycle s=0, so a pulse already high at reset release is never measured.
REQ-017 IDLE: on s=1, go to MEASURE and load the counter with 1.
REQ-018 MEASURE with s=1: counter +1, saturating at all-ones.
REQ-019 MEASURE with s=1, max_width!=0 and counter+1 > max_width: go to OVERRANGE, pulse err_long next cycle, no valid for this pulse.
REQ-020 MEASURE with s=0: load width_out with the counter, pulse valid next cycle, go to IDLE.
REQ-021 On that same cycle, pulse err_short if min_width!=0 and the counter < min_width.
REQ-022 OVERRANGE: wait for s=0, then go to IDLE; no strobes.
REQ-023 Width semantics: pulse_in high on exactly N sampling edges SHALL give width_out=N.
REQ-024 Latency: valid SHALL rise on the 3rd posedge after the first edge that samples pulse_in low.
REQ-025 A width equal to min_width or max_width is legal: no error flag.
REQ-026 pulse_count SHALL increment on every valid, including err_short pulses, and wrap from all-ones to 0.
REQ-027 min_width and max_width are sampled every cycle; changing them mid-pulse takes effect on the next comparison.
REQ-028 A low gap of one synchronized cycle between pulses SHALL be sufficient: IDLE to MEASURE back-to-back is legal.

Reset
REQ-029 rst_n low SHALL asynchronously clear the synchronizer flops, counter, width_out, pulse_count, all strobes and busy to 0, and force state ARM.
REQ-030 Reset asserted mid-pulse SHALL abandon the measurement with no strobe; after release the block re-arms per REQ-016.

Structure
REQ-031 Package pulse_meter_pkg SHALL hold the state enum (ARM, IDLE, MEASURE, OVERRANGE) and the default CNT_W and CNT_PC constants.
REQ-032 Sub-module sync_2ff (1-bit, async active-low reset) SHALL implement REQ-014 and be reusable by other receivers.
REQ-033 All outputs SHALL be registered; there is no combinational path from pulse_in to any output.

Verification
REQ-034 Reset, min=0, max=0, pulse_in high 10 cycles -> width_out=10, valid 1 cycle, no errors, pulse_count=1.
REQ-035 min=5, pulses of 4 then 5 cycles -> first: valid and err_short, width_out=4; second: valid only, width_out=5; pulse_count=2.
REQ-036 max=8, pulse 20 cycles -> err_long once, at the cycle the count would reach 9; no valid; busy held until fall, then IDLE.
REQ-037 pulse_in high across rst_n release, low after 6 cycles, then a 3-cycle pulse -> only width_out=3 reported.
REQ-038 rst_n asserted at cycle 4 of a 10-cycle pulse -> all outputs 0 immediately; no valid; pulse_count=0.
REQ-039 pulse_count preset near wrap (CNT_PC=4 build), 17 pulses -> count reads 1; gap-1 back-to-back pulses of 2 cycles each all measured as 2.
